// File: rtl/prbs5_checker.sv
// prbs5_checker
//   Serial PRBS-5 (x^5+x^2+1) receive checker. It hunts for the pattern in the
//   incoming bit stream and qualifies it over LOCK_CNT consecutive matching bits.
//   Once locked it runs a flywheel: it regenerates the sequence locally and
//   counts every received bit that disagrees with it. Lock is dropped when too
//   many errors land in one evaluation window.
//
//   Optional feature macro: PRBS5_INV_EN
//     defined   -> adds input 'inv'; inv=1 checks the bit-inverted stream
//     undefined -> no 'inv' port; the stream is checked non-inverted
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   din_vld    in   1      din carries a valid bit this cycle
//   din        in   1      received serial bit
//   inv        in   1      (PRBS5_INV_EN only) check inverted stream, static
//   cnt_clr    in   1      synchronous clear of err_cnt
//   locked     out  1      checker is in LOCKED state
//   err_pulse  out  1      one-cycle flag: a mismatched bit was counted
//   err_cnt    out  CNT_W  saturating error count, advances only while locked

module prbs5_checker #(
  parameter int unsigned LOCK_CNT = 31,
  parameter int unsigned ERR_THR  = 4,
  parameter int unsigned WIN_LEN  = 31,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_vld,
  input  logic             din,
`ifdef PRBS5_INV_EN
  input  logic             inv,
`endif
  input  logic             cnt_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned HIST_W = 5;
  localparam int unsigned HC_W   = 3;
  localparam int unsigned MC_W   = $clog2(LOCK_CNT + 1);
  localparam int unsigned WB_W   = $clog2(WIN_LEN + 1);
  localparam int unsigned WE_W   = $clog2(ERR_THR + 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e              state_q;
  logic [HIST_W-1:0]   h_q;
  logic [HC_W-1:0]     hunt_cnt_q;
  logic [MC_W-1:0]     match_cnt_q;
  logic [WB_W-1:0]     win_bits_q;
  logic [WE_W-1:0]     win_errs_q;
  logic                locked_q;
  logic                err_pulse_q;
  logic [CNT_W-1:0]    err_cnt_q;

  logic                inv_c;
  logic                pred_c;
  logic                mism_c;
  logic                stuck_c;
  logic                cnt_sat_c;
  logic                thr_hit_c;
  logic                win_end_c;
  logic [WE_W-1:0]     win_errs_inc_c;

  // Stream polarity selection
`ifdef PRBS5_INV_EN
  assign inv_c = inv;
`else
  assign inv_c = 1'b0;
`endif

  // Prediction and qualification terms derived from the history register
  always_comb begin
    pred_c         = h_q[2] ^ h_q[4] ^ inv_c;
    mism_c         = din ^ pred_c;
    // An all-idle line (all zeros, or all ones when inverted) trivially
    // satisfies the recurrence, so it must never be allowed to lock.
    stuck_c        = (h_q == {HIST_W{inv_c}});
    cnt_sat_c      = (err_cnt_q == {CNT_W{1'b1}});
    win_errs_inc_c = win_errs_q + WE_W'(mism_c);
    thr_hit_c      = mism_c && (win_errs_q == WE_W'(ERR_THR - 1));
    win_end_c      = (win_bits_q == WB_W'(WIN_LEN - 1));
  end

  // Checker FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      h_q         <= '0;
      hunt_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_bits_q  <= '0;
      win_errs_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (cnt_clr) begin
        err_cnt_q <= '0;
      end

      if (din_vld) begin
        case (state_q)
          // Fill the history with five received bits before predicting
          ST_HUNT: begin
            h_q <= {h_q[HIST_W-2:0], din};
            if (hunt_cnt_q == HC_W'(HIST_W - 1)) begin
              hunt_cnt_q  <= '0;
              match_cnt_q <= '0;
              state_q     <= ST_SYNC;
            end else begin
              hunt_cnt_q <= hunt_cnt_q + HC_W'(1);
            end
          end

          // Count consecutive correct predictions; any miss restarts the run
          ST_SYNC: begin
            h_q <= {h_q[HIST_W-2:0], din};
            if (mism_c || stuck_c) begin
              match_cnt_q <= '0;
            end else if (match_cnt_q == MC_W'(LOCK_CNT - 1)) begin
              match_cnt_q <= '0;
              win_bits_q  <= '0;
              win_errs_q  <= '0;
              locked_q    <= 1'b1;
              state_q     <= ST_LOCKED;
            end else begin
              match_cnt_q <= match_cnt_q + MC_W'(1);
            end
          end

          // Flywheel: history advances on the prediction, so a single
          // flipped bit costs exactly one error instead of three.
          ST_LOCKED: begin
            h_q <= {h_q[HIST_W-2:0], pred_c};
            if (mism_c) begin
              err_pulse_q <= 1'b1;
              if (cnt_clr) begin
                err_cnt_q <= CNT_W'(1);
              end else if (!cnt_sat_c) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
              end
            end
            // Threshold is checked before rollover so it wins on a tie
            if (thr_hit_c) begin
              h_q        <= '0;
              hunt_cnt_q <= '0;
              win_bits_q <= '0;
              win_errs_q <= '0;
              locked_q   <= 1'b0;
              state_q    <= ST_HUNT;
            end else if (win_end_c) begin
              win_bits_q <= '0;
              win_errs_q <= '0;
            end else begin
              win_bits_q <= win_bits_q + WB_W'(1);
              win_errs_q <= win_errs_inc_c;
            end
          end

          default: begin
            h_q      <= '0;
            locked_q <= 1'b0;
            state_q  <= ST_HUNT;
          end
        endcase
      end
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

endmodule
